// File: rtl/uart_baud_gen_frac_pkg.sv
// Shared constants and helpers for the fractional-N UART baud generator.
package uart_baud_gen_frac_pkg;

  // Upper bounds on the fractional divisor width and the oversampling ratio
  localparam int UART_FRAC_BITS_MAX = 8;
  localparam int UART_OS_MAX        = 64;

  // Fixed-point divisor (F fractional bits) that best approximates
  // clock_freq / (baud * os), rounded to the nearest LSB.
  function automatic longint unsigned calc_def_div(input int clock_freq,
                                                   input int baud,
                                                   input int os,
                                                   input int frac_bits);
    longint unsigned num;
    longint unsigned den;
    num = longint'(clock_freq) << frac_bits;
    den = longint'(baud) * longint'(os);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_core.sv
// One fractional-N tick channel: integer down-counter plus an F-bit phase
// accumulator whose carry stretches a period by one cycle.
module frac_div_core
  import uart_baud_gen_frac_pkg::*;
#(
  parameter int IW = 16,
  parameter int F  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  input  logic [IW-1:0] pi,
  input  logic [F-1:0]  pf,
  output logic          tick
);

  logic [IW-1:0] pi_eff;
  logic [IW-1:0] reload;
  logic [F:0]    acc_sum;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [F-1:0]  acc_q, acc_d;
  logic          tick_q, tick_d;

  // Clamp a zero integer period to one so the channel ticks every cycle
  always_comb begin
    pi_eff  = (pi == '0) ? IW'(1) : pi;
    reload  = pi_eff - IW'(1);
    acc_sum = {1'b0, acc_q} + {1'b0, pf};
  end

  // Next-state: restart beats enable, which beats normal counting
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = reload;
      acc_d = '0;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        acc_d  = acc_sum[F-1:0];
        cnt_d  = reload + IW'(acc_sum[F]);
      end else begin
        cnt_d = cnt_q - IW'(1);
      end
    end
  end

  // State registers with synchronous reset to a full period
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= reload;
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Programmable fractional-N baud tick generator: rx tick at BAUD*OVERSAMPLE,
// tx tick at BAUD, both derived from one run-time writable divisor.
module uart_baud_gen_frac
  import uart_baud_gen_frac_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FRAC_BITS  = 4,
  parameter int INT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          div_wr,
  input  logic [INT_WIDTH-1:0]          div_int,
  input  logic [FRAC_BITS-1:0]          div_frac,
  input  logic                          rx_sync,
  output logic [INT_WIDTH+FRAC_BITS-1:0] div_q,
  output logic                          rxclk_en,
  output logic                          txclk_en
);

  localparam int S = $clog2(OVERSAMPLE);
  localparam int W = INT_WIDTH + FRAC_BITS;
  localparam logic [W-1:0] DEF_DIV =
    W'(calc_def_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_BITS));

  logic [W-1:0]           shadow_q, shadow_d;
  logic [W+S-1:0]         tx_full;
  logic [INT_WIDTH+S-1:0] tx_pi;
  logic [FRAC_BITS-1:0]   tx_pf;

  // Shadow divisor; channels see the next value so a write landing on a
  // reload edge is adopted immediately
  always_comb begin
    shadow_d = shadow_q;
    if (rst) begin
      shadow_d = DEF_DIV;
    end else if (div_wr) begin
      shadow_d = {div_int, div_frac};
    end
  end

  // Shadow register update
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // tx period is the rx period scaled by the oversampling ratio
  always_comb begin
    tx_full = {shadow_d, {S{1'b0}}};
    tx_pi   = tx_full[W+S-1:FRAC_BITS];
    tx_pf   = tx_full[FRAC_BITS-1:0];
  end

  frac_div_core #(
    .IW (INT_WIDTH),
    .F  (FRAC_BITS)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .en      (enable),
    .restart (rx_sync),
    .pi      (shadow_d[W-1:FRAC_BITS]),
    .pf      (shadow_d[FRAC_BITS-1:0]),
    .tick    (rxclk_en)
  );

  frac_div_core #(
    .IW (INT_WIDTH + S),
    .F  (FRAC_BITS)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .en      (enable),
    .restart (1'b0),
    .pi      (tx_pi),
    .pf      (tx_pf),
    .tick    (txclk_en)
  );

  assign div_q = shadow_q;

endmodule
